feature_rd_gather: RTL and testbench

- Sits directly downstream of the convolution data-address sequencer.
- Consumes its per-pixel feature coordinate stream (signed hin/win, chin) over a valid/ready handshake.
- Performs padding detection and address generation, then issues reads to the feature buffer SRAM.
- Returns one Tin-wide feature word per accepted coordinate, in order, at a fixed total latency that matches `TOTAL_BUF_RD_LATENCY`; zero words are substituted for padded positions.

---
 rtl/feature_rd_gather.sv | 177 +++++++++++++++++
 tb/tb_feature_rd_gather.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_rd_gather.sv
// Feature-buffer read gather: padding detect, address generation, SRAM read and in-order word return.
// Optional FEAT_RD_PAD_VALUE_EN adds a pad_value input used as the fill element for padded positions.

`ifndef base_Tin
`define base_Tin 4
`endif
`ifndef log2_H
`define log2_H 8
`endif
`ifndef log2_W
`define log2_W 8
`endif
`ifndef log2_CH
`define log2_CH 4
`endif
`ifndef TOTAL_BUF_RD_LATENCY
`define TOTAL_BUF_RD_LATENCY 5
`endif

module feature_rd_gather #(
    parameter int ADDR_W  = 16,
    parameter int DW      = 8,
    parameter int TIN     = `base_Tin,
    parameter int MEM_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [`log2_H-1:0]            Hin,
    input  logic [`log2_W-1:0]            Win,
    input  logic [`log2_H+`log2_W-1:0]    Hin_x_Win,
    input  logic [ADDR_W-1:0]             feature_base_addr,
    input  logic                          hold,
`ifdef FEAT_RD_PAD_VALUE_EN
    input  logic [DW-1:0]                 pad_value,
`endif
    input  logic                          feature_data_vld,
    input  logic [`log2_H:0]              feature_hin,
    input  logic [`log2_W:0]              feature_win,
    input  logic [`log2_CH-1:0]           feature_chin,
    output logic                          feature_data_rdy,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic [TIN*DW-1:0]             mem_rd_data,
    output logic                          dat_vld,
    output logic [TIN*DW-1:0]             dat_out,
    output logic [31:0]                   rd_cnt,
    output logic [31:0]                   pad_cnt
);

    localparam int HW = `log2_H;
    localparam int WW = `log2_W;
    localparam int CW = `log2_CH;
    localparam int XW = HW + WW;

    logic              accept;
    logic              in_pad;
    logic [XW-1:0]     row_prod;

    logic              s1_vld;
    logic              s1_pad;
    logic [ADDR_W-1:0] s1_row_off;
    logic [WW-1:0]     s1_win;
    logic [CW-1:0]     s1_chin;
    logic [CW+XW-1:0]  chin_prod;
    logic [ADDR_W-1:0] addr_n;

    logic              s2_vld;
    logic              s2_pad;
    logic [MEM_LAT-1:0] dly_vld;
    logic [MEM_LAT-1:0] dly_pad;
    logic              out_pad;
    logic [TIN*DW-1:0] fill_word;

    assign accept = feature_data_vld & feature_data_rdy;

    // Sign bit set or magnitude past the edge both mean "outside the image".
    assign in_pad = feature_hin[HW] | feature_win[WW]
                  | (feature_hin[HW-1:0] >= Hin)
                  | (feature_win[WW-1:0] >= Win);

    assign row_prod  = {{WW{1'b0}}, feature_hin[HW-1:0]} * {{HW{1'b0}}, Win};
    assign chin_prod = {{XW{1'b0}}, s1_chin} * {{CW{1'b0}}, Hin_x_Win};
    assign addr_n    = feature_base_addr + ADDR_W'(chin_prod) + s1_row_off + ADDR_W'(s1_win);

`ifdef FEAT_RD_PAD_VALUE_EN
    logic [DW-1:0] s1_pv;
    logic [DW-1:0] s2_pv;
    logic [DW-1:0] dly_pv [MEM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pv <= '0;
            s2_pv <= '0;
            for (int i = 0; i < MEM_LAT; i++) dly_pv[i] <= '0;
        end else begin
            if (accept) s1_pv <= pad_value;
            s2_pv     <= s1_pv;
            dly_pv[0] <= s2_pv;
            for (int i = 1; i < MEM_LAT; i++) dly_pv[i] <= dly_pv[i-1];
        end
    end

    assign fill_word = {TIN{dly_pv[MEM_LAT-1]}};
`else
    assign fill_word = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feature_data_rdy <= 1'b0;
            s1_vld           <= 1'b0;
            s1_pad           <= 1'b0;
            s1_row_off       <= '0;
            s1_win           <= '0;
            s1_chin          <= '0;
        end else begin
            feature_data_rdy <= ~hold;
            s1_vld           <= accept;
            if (accept) begin
                s1_pad     <= in_pad;
                s1_row_off <= ADDR_W'(row_prod);
                s1_win     <= feature_win[WW-1:0];
                s1_chin    <= feature_chin;
            end
        end
    end

    // Address register only moves on a real read so the SRAM bus stays quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld      <= 1'b0;
            s2_pad      <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            s2_vld    <= s1_vld;
            s2_pad    <= s1_pad;
            mem_rd_en <= s1_vld & ~s1_pad;
            if (s1_vld & ~s1_pad) mem_rd_addr <= addr_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_vld <= '0;
            dly_pad <= '0;
            dat_vld <= 1'b0;
            out_pad <= 1'b0;
            dat_out <= '0;
        end else begin
            dly_vld[0] <= s2_vld;
            dly_pad[0] <= s2_pad;
            for (int i = 1; i < MEM_LAT; i++) begin
                dly_vld[i] <= dly_vld[i-1];
                dly_pad[i] <= dly_pad[i-1];
            end
            dat_vld <= dly_vld[MEM_LAT-1];
            out_pad <= dly_vld[MEM_LAT-1] & dly_pad[MEM_LAT-1];
            if (dly_vld[MEM_LAT-1])
                dat_out <= dly_pad[MEM_LAT-1] ? fill_word : mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            pad_cnt <= '0;
        end else begin
            if (start)          rd_cnt <= '0;
            else if (mem_rd_en) rd_cnt <= rd_cnt + 32'd1;
            if (start)                  pad_cnt <= '0;
            else if (dat_vld & out_pad) pad_cnt <= pad_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_feature_rd_gather.sv
// Scoreboard bench for feature_rd_gather: SRAM model, reference address/pad model, directed and random streams.

`ifndef base_Tin
`define base_Tin 4
`endif
`ifndef log2_H
`define log2_H 8
`endif
`ifndef log2_W
`define log2_W 8
`endif
`ifndef log2_CH
`define log2_CH 4
`endif

module tb_feature_rd_gather;
    localparam int ADDR_W  = 16;
    localparam int DW      = 8;
    localparam int TIN     = `base_Tin;
    localparam int MEM_LAT = 2;
    localparam int LAT     = MEM_LAT + 3;
    localparam int HW      = `log2_H;
    localparam int WW      = `log2_W;
    localparam int CW      = `log2_CH;
    localparam int DATA_W  = TIN * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [HW-1:0]     Hin = '0;
    logic [WW-1:0]     Win = '0;
    logic [HW+WW-1:0]  Hin_x_Win = '0;
    logic [ADDR_W-1:0] feature_base_addr = '0;
    logic              hold = 1'b0;
    logic              feature_data_vld = 1'b0;
    logic [HW:0]       feature_hin = '0;
    logic [WW:0]       feature_win = '0;
    logic [CW-1:0]     feature_chin = '0;
    logic              feature_data_rdy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dat_vld;
    logic [DATA_W-1:0] dat_out;
    logic [31:0]       rd_cnt;
    logic [31:0]       pad_cnt;
`ifdef FEAT_RD_PAD_VALUE_EN
    logic [DW-1:0]     pad_value = '0;
`endif

    feature_rd_gather #(.ADDR_W(ADDR_W), .DW(DW), .TIN(TIN), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Hin(Hin), .Win(Win), .Hin_x_Win(Hin_x_Win), .feature_base_addr(feature_base_addr),
        .hold(hold),
`ifdef FEAT_RD_PAD_VALUE_EN
        .pad_value(pad_value),
`endif
        .feature_data_vld(feature_data_vld), .feature_hin(feature_hin),
        .feature_win(feature_win), .feature_chin(feature_chin),
        .feature_data_rdy(feature_data_rdy),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .dat_vld(dat_vld), .dat_out(dat_out), .rd_cnt(rd_cnt), .pad_cnt(pad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DATA_W-1:0] data; int cyc; } dat_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; int cyc; } rd_exp_t;

    dat_exp_t exp_dat[$];
    rd_exp_t  exp_rd[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_rd    = 0;
    int m_pad   = 0;
    logic rdy_exp;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < TIN; i++)
            w[i*DW +: DW] = 8'((int'(a) * 7 + i * 29 + int'(a >> 8)) & 255);
        return w;
    endfunction

    // SRAM: data for a read appears MEM_LAT cycles after the strobe.
    logic [DATA_W-1:0] sram_pipe [MEM_LAT];
    always @(posedge clk) begin
        sram_pipe[0] <= mem_rd_en ? sram_word(mem_rd_addr) : '0;
        for (int i = 1; i < MEM_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign mem_rd_data = sram_pipe[MEM_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) rdy_exp <= 1'b0;
        else        rdy_exp <= ~hold;

    // Reference model on accept, plus checking of every DUT presentation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rdy", feature_data_rdy, rdy_exp);
            if (feature_data_vld && feature_data_rdy) begin
                int h, w, a;
                bit pad;
                dat_exp_t d;
                rd_exp_t  r;
                h   = int'($signed(feature_hin));
                w   = int'($signed(feature_win));
                pad = (h < 0) || (w < 0) || (h >= int'(Hin)) || (w >= int'(Win));
                d.cyc = cyc + LAT;
                if (pad) begin
`ifdef FEAT_RD_PAD_VALUE_EN
                    d.data = {TIN{pad_value}};
`else
                    d.data = '0;
`endif
                    m_pad++;
                end else begin
                    a = (int'(feature_base_addr) + int'(feature_chin) * int'(Hin_x_Win)
                         + h * int'(Win) + w) % 65536;
                    r.addr = ADDR_W'(a);
                    r.cyc  = cyc + 2;
                    d.data = sram_word(r.addr);
                    exp_rd.push_back(r);
                    m_rd++;
                end
                exp_dat.push_back(d);
            end
            if (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                chk("missing mem_rd_en", 0, 1);
                void'(exp_rd.pop_front());
            end
            if (exp_dat.size() > 0 && exp_dat[0].cyc < cyc) begin
                chk("missing dat_vld", 0, 1);
                void'(exp_dat.pop_front());
            end
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) chk("unexpected mem_rd_en", 1, 0);
                else begin
                    rd_exp_t r;
                    r = exp_rd.pop_front();
                    chk("mem_rd_addr", mem_rd_addr, r.addr);
                    chk("mem_rd_en cycle", cyc, r.cyc);
                end
            end
            if (dat_vld) begin
                if (exp_dat.size() == 0) chk("unexpected dat_vld", 1, 0);
                else begin
                    dat_exp_t d;
                    d = exp_dat.pop_front();
                    chk("dat_out", dat_out, d.data);
                    chk("dat_vld cycle", cyc, d.cyc);
                end
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic send(input int h, input int w, input int c);
        bit done = 0;
        feature_data_vld = 1'b1;
        feature_hin  = (HW+1)'(h);
        feature_win  = (WW+1)'(w);
        feature_chin = CW'(c);
`ifdef FEAT_RD_PAD_VALUE_EN
        pad_value = DW'($urandom);
`endif
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (feature_data_rdy) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("accept timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        feature_data_vld = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        feature_data_vld = 1'b0;
        for (int i = 0; i < 100 && (exp_dat.size() > 0 || exp_rd.size() > 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain pending", exp_dat.size() + exp_rd.size(), 0);
        idle(2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_rd = 0;
        m_pad = 0;
        chk("rd_cnt after start", rd_cnt, 0);
        chk("pad_cnt after start", pad_cnt, 0);
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, " rd_cnt"}, rd_cnt, 32'(m_rd));
        chk({tag, " pad_cnt"}, pad_cnt, 32'(m_pad));
    endtask

    task automatic check_reset_outs();
        chk("rst rdy", feature_data_rdy, 0);
        chk("rst mem_rd_en", mem_rd_en, 0);
        chk("rst mem_rd_addr", mem_rd_addr, 0);
        chk("rst dat_vld", dat_vld, 0);
        chk("rst dat_out", dat_out, 0);
        chk("rst rd_cnt", rd_cnt, 0);
        chk("rst pad_cnt", pad_cnt, 0);
    endtask

    task automatic config_layer(input int h, input int w, input int hxw, input int base);
        Hin = HW'(h);
        Win = WW'(w);
        Hin_x_Win = (HW+WW)'(hxw);
        feature_base_addr = ADDR_W'(base);
    endtask

    initial begin
        #2;
        check_reset_outs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy first cycle after reset", feature_data_rdy, 0);
        @(posedge clk); #1;

        // Single in-range beat: read 0x106 two cycles after accept.
        config_layer(4, 4, 16, 'h100);
        pulse_start();
        send(1, 2, 0);
        drain();
        check_cnt("single");

        // Three padded positions.
        pulse_start();
        send(-1, 0, 0);
        send(0, 4, 0);
        send(4, 3, 1);
        drain();
        check_cnt("pad");
        chk("pad test pad_cnt", pad_cnt, 3);

        // 3x3 kernel, stride 2, pad 1 over 4x4: 36 beats.
        pulse_start();
        for (int oh = 0; oh < 2; oh++)
            for (int ow = 0; ow < 2; ow++)
                for (int kh = 0; kh < 3; kh++)
                    for (int kw = 0; kw < 3; kw++)
                        send(oh*2 - 1 + kh, ow*2 - 1 + kw, 0);
        drain();
        check_cnt("sweep");
        chk("sweep rd_cnt const", rd_cnt, 25);
        chk("sweep pad_cnt const", pad_cnt, 11);

        // Hold for 5 cycles in the middle of a back-to-back stream.
        fork
            begin
                repeat (4) @(posedge clk);
                #1 hold = 1'b1;
                repeat (5) @(posedge clk);
                #1 hold = 1'b0;
            end
        join_none
        for (int i = 0; i < 12; i++) send(i % 4, (i / 4) % 4, i % 2);
        drain();
        check_cnt("hold");

        // Address wrap through the channel-group stride.
        config_layer(128, 128, 'h4000, 'hF000);
        pulse_start();
        send(1, 2, 3);
        send(0, 0, 3);
        send(127, 127, 2);
        drain();
        check_cnt("wrap");

        // Reset with three words in flight.
        config_layer(4, 4, 16, 'h100);
        send(0, 1, 0);
        send(-1, 1, 0);
        send(2, 2, 0);
        feature_data_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        exp_dat.delete();
        exp_rd.delete();
        m_rd = 0;
        m_pad = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(12);
        send(3, 3, 0);
        drain();
        check_cnt("post reset");

        // Randomised layers with random hold bursts and gaps.
        for (int layer = 0; layer < 4; layer++) begin
            int hh, ww;
            hh = int'($urandom_range(1, 8));
            ww = int'($urandom_range(1, 8));
            config_layer(hh, ww, hh * ww, int'($urandom_range(0, 65535)));
            pulse_start();
            for (int b = 0; b < 60; b++) begin
                if ($urandom_range(0, 5) == 0) begin
                    hold = 1'b1;
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    hold = 1'b0;
                end
                send(int'($urandom_range(0, hh + 3)) - 2, int'($urandom_range(0, ww + 3)) - 2,
                     int'($urandom_range(0, (1 << CW) - 1)));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
            drain();
            check_cnt("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
